combat_resolver: RTL and testbench

Referee block between the two `player` instances. Each frame it takes both players' state codes and boxes, detects hitbox/hurtbox overlap during attack-active states, and issues one-cycle `hitFlag` pulses. It also owns each player's `health` and `block` counters, and runs a FIGHT/KO round FSM that declares the winner.

---
 rtl/combat_resolver.sv | 206 ++++++++++++++++++++
 tb/tb_combat_resolver.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/combat_resolver.sv
// combat_resolver: two-player hit detection, health/block bookkeeping and FIGHT/KO round FSM.
// Define COMBAT_CHIP_DAMAGE_EN to make blocked hits also cost 1 health.
module combat_resolver #(
  parameter int HEALTH_INIT = 5,
  parameter int BLOCK_INIT  = 3,
  parameter int BLOCK_REGEN = 60,
  parameter int DMG_BASIC   = 1,
  parameter int DMG_DIR     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic [3:0]  p1_state,
  input  logic [3:0]  p2_state,
  input  logic [39:0] p1_basic_box,
  input  logic [39:0] p2_basic_box,
  input  logic [39:0] p1_dir_box,
  input  logic [39:0] p2_dir_box,
  input  logic [39:0] p1_hurt_box,
  input  logic [39:0] p2_hurt_box,
  output logic [1:0]  p1_hitFlag,
  output logic [1:0]  p2_hitFlag,
  output logic [2:0]  p1_health,
  output logic [2:0]  p2_health,
  output logic [2:0]  p1_block,
  output logic [2:0]  p2_block,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam logic [3:0] ST_MOVEBACK = 4'd2;
  localparam logic [3:0] ST_B_END    = 4'd4;
  localparam logic [3:0] ST_D_END    = 4'd7;
  localparam logic [3:0] ST_BSTUN    = 4'd10;

  localparam int CW = $clog2(BLOCK_REGEN + 1);
  localparam logic [2:0]    H_INIT     = 3'(HEALTH_INIT);
  localparam logic [2:0]    B_INIT     = 3'(BLOCK_INIT);
  localparam logic [2:0]    D_BASIC    = 3'(DMG_BASIC);
  localparam logic [2:0]    D_DIR      = 3'(DMG_DIR);
  localparam logic [CW-1:0] REGEN_LAST = CW'(BLOCK_REGEN - 1);

  typedef enum logic {FIGHT = 1'b0, KO = 1'b1} round_t;

  round_t     state_q, state_d;
  logic [1:0] winner_q, winner_d;
  logic [1:0] health_zero;
  logic       ko_now, det_en, restart_go;

  // Per-player views, index 0 = p1, index 1 = p2
  logic [3:0]  st   [2];
  logic [39:0] bbox [2];
  logic [39:0] dbox [2];
  logic [39:0] hurt [2];
  logic [2:0]  health_w [2];
  logic [2:0]  block_w  [2];
  logic [1:0]  hit_w    [2];

  assign st[0]   = p1_state;
  assign st[1]   = p2_state;
  assign bbox[0] = p1_basic_box;
  assign bbox[1] = p2_basic_box;
  assign dbox[0] = p1_dir_box;
  assign dbox[1] = p2_dir_box;
  assign hurt[0] = p1_hurt_box;
  assign hurt[1] = p2_hurt_box;

  // Boxes are {x1,x2,y1,y2}; touching edges count as overlap
  function automatic logic overlap(input logic [39:0] a, input logic [39:0] b);
    return (a[39:30] <= b[29:20]) && (b[39:30] <= a[29:20]) &&
           (a[19:10] <= b[9:0])   && (b[19:10] <= a[9:0]);
  endfunction

  function automatic logic [2:0] sat_sub(input logic [2:0] v, input logic [2:0] d);
    return (v > d) ? (v - d) : 3'd0;
  endfunction

  always_comb begin
    health_zero = {health_w[1] == 3'd0, health_w[0] == 3'd0};
    ko_now      = |health_zero;
    det_en      = (state_q == FIGHT) && !ko_now;
    restart_go  = (state_q == KO) && restart;
    state_d     = state_q;
    winner_d    = winner_q;
    case (state_q)
      FIGHT: begin
        if (ko_now) begin
          state_d = KO;
          case (health_zero)
            2'b11:   winner_d = 2'b11;
            2'b01:   winner_d = 2'b10;
            default: winner_d = 2'b01;
          endcase
        end
      end
      KO: begin
        if (restart) begin
          state_d  = FIGHT;
          winner_d = 2'b00;
        end
      end
      default: state_d = FIGHT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FIGHT;
      winner_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
    end
  end

  // Each instance holds victim g's counters plus the one-hit latch of its attacker
  for (genvar g = 0; g < 2; g++) begin : g_pl
    localparam int A = 1 - g;

    logic          b_hit, d_hit, lands;
    logic [1:0]    hit_q, hit_d;
    logic          blk_q, blk_d;
    logic          conn_q, conn_d;
    logic [2:0]    health_q, health_d;
    logic [2:0]    block_q, block_d;
    logic [CW-1:0] regen_q, regen_d;
    logic [2:0]    dmg;

    always_comb begin
      b_hit  = (st[A] == ST_B_END) && overlap(bbox[A], hurt[g]);
      d_hit  = (st[A] == ST_D_END) && overlap(dbox[A], hurt[g]);
      lands  = det_en && !conn_q && (b_hit || d_hit);
      hit_d  = 2'b00;
      blk_d  = 1'b0;
      if (lands) begin
        hit_d = b_hit ? 2'b01 : 2'b10;
        blk_d = (st[g] == ST_MOVEBACK) && (block_q != 3'd0);
      end
      conn_d = conn_q | lands;
      if ((st[A] != ST_B_END) && (st[A] != ST_D_END)) conn_d = 1'b0;

      health_d = health_q;
      block_d  = block_q;
      regen_d  = regen_q;
      dmg      = (hit_q == 2'b01) ? D_BASIC : D_DIR;
      if (state_q == FIGHT) begin
        if ((hit_q != 2'b00) && !blk_q) health_d = sat_sub(health_q, dmg);
        if (blk_q) begin
          block_d = block_q - 3'd1;
          regen_d = '0;
`ifdef COMBAT_CHIP_DAMAGE_EN
          health_d = sat_sub(health_q, 3'd1);
`endif
        end else if ((st[g] != ST_BSTUN) && (block_q < B_INIT)) begin
          if (regen_q == REGEN_LAST) begin
            regen_d = '0;
            block_d = block_q + 3'd1;
          end else begin
            regen_d = regen_q + CW'(1);
          end
        end
      end

      if (restart_go) begin
        hit_d    = 2'b00;
        blk_d    = 1'b0;
        conn_d   = 1'b0;
        health_d = H_INIT;
        block_d  = B_INIT;
        regen_d  = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hit_q    <= 2'b00;
        blk_q    <= 1'b0;
        conn_q   <= 1'b0;
        health_q <= H_INIT;
        block_q  <= B_INIT;
        regen_q  <= '0;
      end else begin
        hit_q    <= hit_d;
        blk_q    <= blk_d;
        conn_q   <= conn_d;
        health_q <= health_d;
        block_q  <= block_d;
        regen_q  <= regen_d;
      end
    end

    assign health_w[g] = health_q;
    assign block_w[g]  = block_q;
    assign hit_w[g]    = hit_q;
  end

  assign p1_hitFlag = hit_w[0];
  assign p2_hitFlag = hit_w[1];
  assign p1_health  = health_w[0];
  assign p2_health  = health_w[1];
  assign p1_block   = block_w[0];
  assign p2_block   = block_w[1];
  assign game_over  = (state_q == KO);
  assign winner     = winner_q;

endmodule

// File: tb/tb_combat_resolver.sv
// Directed bench for combat_resolver: hit events go through an expected queue checked by a
// monitor; health/block/round outputs are checked directly against hand-computed values.
module tb_combat_resolver;

`ifdef COMBAT_CHIP_DAMAGE_EN
  localparam int CHIP = 1;
`else
  localparam int CHIP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, restart;
  logic [3:0]  p1_state, p2_state;
  logic [39:0] p1_basic_box, p2_basic_box, p1_dir_box, p2_dir_box, p1_hurt_box, p2_hurt_box;
  logic [1:0]  p1_hitFlag, p2_hitFlag;
  logic [2:0]  p1_health, p2_health, p1_block, p2_block;
  logic        game_over;
  logic [1:0]  winner;

  logic [3:0] exp_q[$];
  logic [3:0] mon_e;
  int n_checks = 0;
  int n_fail   = 0;

  combat_resolver dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .p1_state(p1_state), .p2_state(p2_state),
    .p1_basic_box(p1_basic_box), .p2_basic_box(p2_basic_box),
    .p1_dir_box(p1_dir_box), .p2_dir_box(p2_dir_box),
    .p1_hurt_box(p1_hurt_box), .p2_hurt_box(p2_hurt_box),
    .p1_hitFlag(p1_hitFlag), .p2_hitFlag(p2_hitFlag),
    .p1_health(p1_health), .p2_health(p2_health),
    .p1_block(p1_block), .p2_block(p2_block),
    .game_over(game_over), .winner(winner)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected test end");
    $fatal(1, "watchdog");
  end

  function automatic logic [39:0] box(input logic [9:0] x1, input logic [9:0] x2,
                                      input logic [9:0] y1, input logic [9:0] y2);
    return {x1, x2, y1, y2};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    p1_state     = 4'd0;
    p2_state     = 4'd0;
    p1_basic_box = box(0, 10, 500, 510);
    p1_dir_box   = box(0, 10, 500, 510);
    p2_basic_box = box(600, 610, 500, 510);
    p2_dir_box   = box(600, 610, 500, 510);
    p1_hurt_box  = box(100, 150, 100, 200);
    p2_hurt_box  = box(300, 350, 100, 200);
  endtask

  task automatic hold_then_idle(input int n);
    repeat (n) cyc();
    set_idle();
    repeat (2) cyc();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Scoreboard monitor: every nonzero flag cycle must match the next expected hit event
  always @(negedge clk) begin
    if (rst_n && ((p1_hitFlag != 2'b00) || (p2_hitFlag != 2'b00))) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_hit: got p1=%b p2=%b expected no hit", p1_hitFlag, p2_hitFlag);
      end else begin
        mon_e = exp_q.pop_front();
        if ({p1_hitFlag, p2_hitFlag} !== mon_e) begin
          n_fail++;
          $display("FAIL hit_event: got p1=%b p2=%b expected p1=%b p2=%b",
                   p1_hitFlag, p2_hitFlag, mon_e[3:2], mon_e[1:0]);
        end
      end
    end
  end

  initial begin
    restart = 1'b0;
    do_reset();
    check("reset_p1_health", p1_health, 5);
    check("reset_p2_health", p2_health, 5);
    check("reset_p1_block", p1_block, 3);
    check("reset_p2_block", p2_block, 3);
    check("reset_game_over", game_over, 0);
    check("reset_winner", winner, 0);
    check("reset_flags", {p1_hitFlag, p2_hitFlag}, 0);

    // Unblocked basic hit held 3 cycles: one flag, health drops one cycle after it
    exp_q.push_back(4'b0001);
    p1_state = 4'd4;
    p1_basic_box = box(140, 320, 150, 160);
    cyc();
    check("basic_pre_update", p2_health, 5);
    cyc();
    check("basic_post_update", p2_health, 4);
    hold_then_idle(1);
    check("basic_attacker_health", p1_health, 5);

    // Touching edge counts, one-pixel gap does not
    exp_q.push_back(4'b0001);
    p1_state = 4'd4;
    p1_basic_box = box(140, 300, 150, 160);
    hold_then_idle(3);
    check("edge_touch_health", p2_health, 3);
    p1_state = 4'd4;
    p1_basic_box = box(140, 299, 150, 160);
    hold_then_idle(3);
    check("edge_gap_health", p2_health, 3);

    // Blocked directional hits
    exp_q.push_back(4'b0010);
    p2_state = 4'd2;
    p1_state = 4'd7;
    p1_dir_box = box(140, 320, 100, 120);
    cyc();
    check("block1_pre_update", p2_block, 3);
    cyc();
    check("block1_block", p2_block, 2);
    check("block1_health", p2_health, 3 - CHIP);
    hold_then_idle(1);

    exp_q.push_back(4'b0010);
    p2_state = 4'd2;
    p1_state = 4'd7;
    p1_dir_box = box(140, 320, 100, 120);
    cyc();
    cyc();
    check("block2_block", p2_block, 1);
    check("block2_health", p2_health, 3 - 2 * CHIP);

    // Regen: counter restarted at the last blocked update, +1 every 60 cycles, capped at 3
    cyc();
    set_idle();
    repeat (63) cyc();
    check("regen_first", p2_block, 2);
    repeat (60) cyc();
    check("regen_second", p2_block, 3);
    repeat (60) cyc();
    check("regen_cap", p2_block, 3);

    // Asynchronous reset in the middle of a hit pulse
    p2_state = 4'd2;
    p1_state = 4'd7;
    p1_dir_box = box(140, 320, 100, 120);
    cyc();
    check("pulse_before_reset", p2_hitFlag, 2);
    #1 rst_n = 1'b0;
    #1;
    check("async_flags", {p1_hitFlag, p2_hitFlag}, 0);
    check("async_p2_health", p2_health, 5);
    check("async_p2_block", p2_block, 3);
    check("async_winner", winner, 0);
    set_idle();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Basic trade, then restart must be ignored in FIGHT
    exp_q.push_back(4'b0101);
    p1_state = 4'd4;
    p2_state = 4'd4;
    p1_basic_box = box(140, 320, 150, 160);
    p2_basic_box = box(120, 310, 150, 160);
    hold_then_idle(3);
    check("trade_p1_health", p1_health, 4);
    check("trade_p2_health", p2_health, 4);
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    cyc();
    check("restart_ignored", p1_health, 4);

    // Directional trade 4->2, basic trade 2->1
    exp_q.push_back(4'b1010);
    p1_state = 4'd7;
    p2_state = 4'd7;
    p1_dir_box = box(140, 320, 100, 120);
    p2_dir_box = box(120, 310, 100, 120);
    hold_then_idle(3);
    check("dtrade_p1_health", p1_health, 2);
    exp_q.push_back(4'b0101);
    p1_state = 4'd4;
    p2_state = 4'd4;
    p1_basic_box = box(140, 320, 150, 160);
    p2_basic_box = box(120, 310, 150, 160);
    hold_then_idle(3);
    check("btrade_p2_health", p2_health, 1);

    // Final mutual directional hit: draw
    exp_q.push_back(4'b1010);
    p1_state = 4'd7;
    p2_state = 4'd7;
    p1_dir_box = box(140, 320, 100, 120);
    p2_dir_box = box(120, 310, 100, 120);
    cyc();
    cyc();
    check("ko_p1_health", p1_health, 0);
    check("ko_p2_health", p2_health, 0);
    check("ko_not_yet", game_over, 0);
    cyc();
    check("ko_game_over", game_over, 1);
    check("ko_winner", winner, 3);
    p1_state = 4'd0;
    p2_state = 4'd0;
    cyc();
    p1_state = 4'd7;
    p2_state = 4'd7;
    repeat (5) cyc();
    check("ko_flags_quiet", {p1_hitFlag, p2_hitFlag}, 0);
    set_idle();
    cyc();
    check("ko_holds", game_over, 1);
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    check("restart_p1_health", p1_health, 5);
    check("restart_p2_health", p2_health, 5);
    check("restart_p1_block", p1_block, 3);
    check("restart_p2_block", p2_block, 3);
    check("restart_winner", winner, 0);
    check("restart_game_over", game_over, 0);
    repeat (2) cyc();

    check("hits_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
